// File: rtl/xadc_joystick_scanner.sv
// xadc_joystick_scanner
//   Round-robin XADC DRP reader plus per-channel joystick direction quantiser.
//   Each end-of-conversion in IDLE triggers one DRP read of BASE_ADDR+ch. The
//   returned sample is stored. It is also turned into a LOW/CENTRE/HIGH code,
//   with hysteresis and persistence filtering applied.
//
// Ports
//   i_clk      system clock
//   i_rst      asynchronous active-high reset
//   i_eoc      XADC end-of-conversion (ignored unless idle)
//   o_den      DRP enable, one-cycle pulse
//   o_daddr    DRP address, held between requests
//   i_drdy     DRP data ready (ignored unless waiting)
//   i_do       DRP read data, sample taken from the top SAMPLE_W bits
//   o_dir      per-channel code, [2k+1:2k]: 0 LOW, 1 CENTRE, 2 HIGH
//   o_sample   last captured sample per channel
//   o_valid    one-cycle capture strobe per channel
//   o_timeout  one-cycle pulse when a DRP read is abandoned
//   o_err      sticky timeout flag, cleared only by reset
module xadc_joystick_scanner #(
    parameter int unsigned NUM_CH    = 2,
    parameter logic [6:0]  BASE_ADDR = 7'h16,
    parameter int unsigned SAMPLE_W  = 12,
    parameter int unsigned HI_THRESH = 'hE00,
    parameter int unsigned LO_THRESH = 'h100,
    parameter int unsigned HYST      = 'h080,
    parameter int unsigned PERSIST   = 2,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_eoc,
    output logic                         o_den,
    output logic [6:0]                   o_daddr,
    input  logic                         i_drdy,
    input  logic [15:0]                  i_do,
    output logic [2*NUM_CH-1:0]          o_dir,
    output logic [SAMPLE_W*NUM_CH-1:0]   o_sample,
    output logic [NUM_CH-1:0]            o_valid,
    output logic                         o_timeout,
    output logic                         o_err
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned P_W   = $clog2(PERSIST + 1);

    localparam logic [SAMPLE_W-1:0] HI_T   = SAMPLE_W'(HI_THRESH);
    localparam logic [SAMPLE_W-1:0] LO_T   = SAMPLE_W'(LO_THRESH);
    localparam logic [SAMPLE_W-1:0] HI_REL = SAMPLE_W'(HI_THRESH - HYST);
    localparam logic [SAMPLE_W-1:0] LO_REL = SAMPLE_W'(LO_THRESH + HYST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_e;

    typedef enum logic [1:0] {
        DIR_LOW    = 2'd0,
        DIR_CENTRE = 2'd1,
        DIR_HIGH   = 2'd2
    } dir_e;

    state_e                state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [6:0]            daddr_q, daddr_d;
    logic [TMO_W-1:0]      tcnt_q, tcnt_d;
    logic [SAMPLE_W-1:0]   sample_q [NUM_CH];
    logic [SAMPLE_W-1:0]   sample_d [NUM_CH];
    dir_e                  dir_q    [NUM_CH];
    dir_e                  dir_d    [NUM_CH];
    dir_e                  cand_q   [NUM_CH];
    dir_e                  cand_d   [NUM_CH];
    logic [P_W-1:0]        pcnt_q   [NUM_CH];
    logic [P_W-1:0]        pcnt_d   [NUM_CH];
    logic [NUM_CH-1:0]     valid_q, valid_d;
    logic                  timeout_q, timeout_d;
    logic                  err_q, err_d;

    logic [SAMPLE_W-1:0]   new_s;
    logic [CH_W-1:0]       ch_next;
    dir_e                  c;
    logic [P_W-1:0]        pc;
    logic                  unused_do;

    // Low-order DRP bits below the sample field carry no information.
    assign unused_do = ^i_do;

    // Holding an existing HIGH/LOW uses the relaxed release threshold;
    // failing that, the sample is classified exactly as from CENTRE.
    function automatic dir_e candidate(input dir_e d, input logic [SAMPLE_W-1:0] s);
        dir_e r;
        if (s >= HI_T)      r = DIR_HIGH;
        else if (s < LO_T)  r = DIR_LOW;
        else                r = DIR_CENTRE;
        if (d == DIR_HIGH && s >= HI_REL) r = DIR_HIGH;
        if (d == DIR_LOW  && s <  LO_REL) r = DIR_LOW;
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        daddr_d   = daddr_q;
        tcnt_d    = tcnt_q;
        sample_d  = sample_q;
        dir_d     = dir_q;
        cand_d    = cand_q;
        pcnt_d    = pcnt_q;
        valid_d   = '0;
        timeout_d = 1'b0;
        err_d     = err_q;
        new_s     = i_do[15 -: SAMPLE_W];
        ch_next   = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
        c         = DIR_CENTRE;
        pc        = '0;

        case (state_q)
            S_IDLE: begin
                if (i_eoc) begin
                    state_d = S_REQ;
                    daddr_d = BASE_ADDR + 7'(ch_q);
                end
            end
            S_REQ: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // i_drdy is tested first so it wins over the terminal count.
                if (i_drdy) begin
                    sample_d[ch_q] = new_s;
                    valid_d[ch_q]  = 1'b1;
                    c = candidate(dir_q[ch_q], new_s);
                    if (c == dir_q[ch_q])
                        pc = '0;
                    else if (c != cand_q[ch_q])
                        pc = P_W'(1);
                    else if (pcnt_q[ch_q] < P_W'(PERSIST))
                        pc = pcnt_q[ch_q] + 1'b1;
                    else
                        pc = pcnt_q[ch_q];
                    if (pc == P_W'(PERSIST)) begin
                        dir_d[ch_q] = c;
                        pc          = '0;
                    end
                    pcnt_d[ch_q] = pc;
                    cand_d[ch_q] = c;
                    ch_d         = ch_next;
                    state_d      = S_IDLE;
                end else if (tcnt_q == TMO_W'(TIMEOUT - 1)) begin
                    // TIMEOUT wait cycles elapsed; pulse lands TIMEOUT+1 after o_den.
                    timeout_d = 1'b1;
                    err_d     = 1'b1;
                    ch_d      = ch_next;
                    state_d   = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            daddr_q   <= BASE_ADDR;
            tcnt_q    <= '0;
            valid_q   <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                sample_q[k] <= '0;
                dir_q[k]    <= DIR_CENTRE;
                cand_q[k]   <= DIR_CENTRE;
                pcnt_q[k]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            daddr_q   <= daddr_d;
            tcnt_q    <= tcnt_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            sample_q  <= sample_d;
            dir_q     <= dir_d;
            cand_q    <= cand_d;
            pcnt_q    <= pcnt_d;
        end
    end

    always_comb begin
        o_dir    = '0;
        o_sample = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            o_dir[2*k +: 2]               = dir_q[k];
            o_sample[SAMPLE_W*k +: SAMPLE_W] = sample_q[k];
        end
    end

    assign o_den     = (state_q == S_REQ);
    assign o_daddr   = daddr_q;
    assign o_valid   = valid_q;
    assign o_timeout = timeout_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_xadc_joystick_scanner.sv
// tb_xadc_joystick_scanner
//   Directed bench for xadc_joystick_scanner. A default two-channel instance
//   and a three-channel instance share the same stimulus.
module tb_xadc_joystick_scanner;

    logic        clk;
    logic        rst;
    logic        eoc;
    logic        drdy;
    logic [15:0] din;

    logic        den2, tmo2, err2;
    logic [6:0]  addr2;
    logic [3:0]  dir2;
    logic [23:0] smp2;
    logic [1:0]  vld2;

    logic        den3, tmo3, err3;
    logic [6:0]  addr3;
    logic [5:0]  dir3;
    logic [35:0] smp3;
    logic [2:0]  vld3;

    int n_checks = 0;
    int n_errors = 0;

    logic        den_seen;
    logic [6:0]  a2_seen, a3_seen;
    int          cyc;

    xadc_joystick_scanner dut2 (
        .i_clk(clk), .i_rst(rst), .i_eoc(eoc), .o_den(den2), .o_daddr(addr2),
        .i_drdy(drdy), .i_do(din), .o_dir(dir2), .o_sample(smp2),
        .o_valid(vld2), .o_timeout(tmo2), .o_err(err2)
    );

    xadc_joystick_scanner #(.NUM_CH(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_eoc(eoc), .o_den(den3), .o_daddr(addr3),
        .i_drdy(drdy), .i_do(din), .o_dir(dir3), .o_sample(smp3),
        .o_valid(vld3), .o_timeout(tmo3), .o_err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // One full eoc/drdy transaction; returns in the cycle the capture is visible.
    task automatic rd(input logic [15:0] d);
        eoc = 1'b1;
        tick();
        den_seen = den2;
        a2_seen  = addr2;
        a3_seen  = addr3;
        eoc = 1'b0;
        tick();
        din  = d;
        drdy = 1'b1;
        tick();
        drdy = 1'b0;
    endtask

    logic [11:0] hy_val [6] = '{12'hD90, 12'hD90, 12'hD70, 12'hD70, 12'h0F0, 12'h0F0};
    logic [1:0]  hy_exp [6] = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    logic [6:0]  seq_a  [4] = '{7'h16, 7'h17, 7'h18, 7'h16};
    logic [2:0]  seq_v  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    initial begin
        rst = 1'b0; eoc = 1'b0; drdy = 1'b0; din = '0;
        do_reset();

        // Reset values
        check("rst_den",   48'(den2),  48'd0);
        check("rst_addr",  48'(addr2), 48'h16);
        check("rst_dir",   48'(dir2),  48'h5);
        check("rst_dir3",  48'(dir3),  48'h15);
        check("rst_smp",   48'(smp2),  48'h0);
        check("rst_vld",   48'(vld2),  48'h0);
        check("rst_tmo",   48'(tmo2),  48'h0);
        check("rst_err",   48'(err2),  48'h0);

        // First read: ch0 HIGH candidate, not yet committed
        rd(16'hF000);
        check("r1_den",  48'(den_seen), 48'd1);
        check("r1_addr", 48'(a2_seen),  48'h16);
        check("r1_smp",  48'(smp2[11:0]), 48'hF00);
        check("r1_vld",  48'(vld2),       48'h1);
        check("r1_dir",  48'(dir2[1:0]),  48'h1);
        tick();
        check("r1_vld_end", 48'(vld2), 48'h0);
        check("r1_den_end", 48'(den2), 48'h0);

        rd(16'h8000);
        check("r2_addr", 48'(a2_seen), 48'h17);
        check("r2_vld",  48'(vld2),    48'h2);
        check("r2_smp",  48'(smp2),    48'h800F00);
        rd(16'hF000);
        check("r3_dir",  48'(dir2),    48'h6);

        // Hysteresis from HIGH, ch1 kept at centre between ch0 reads
        for (int i = 0; i < 6; i++) begin
            rd(16'h8000);
            rd({hy_val[i], 4'h0});
            check($sformatf("hyst%0d", i), 48'(dir2[1:0]), 48'(hy_exp[i]));
        end
        check("hyst_ch1", 48'(dir2[3:2]), 48'h1);

        // Persistence: alternating candidates never commit
        do_reset();
        for (int i = 0; i < 6; i++) begin
            rd((i % 2 == 0) ? 16'hF000 : 16'h0500);
            check($sformatf("pers%0d", i), 48'(dir2[1:0]), 48'h1);
            rd(16'h8000);
        end

        // drdy coinciding with terminal count is captured, no timeout
        do_reset();
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        for (int i = 0; i < 255; i++) tick();
        din  = 16'h1230;
        drdy = 1'b1;
        tick();
        drdy = 1'b0;
        check("edge_vld", 48'(vld2), 48'h1);
        check("edge_tmo", 48'(tmo2), 48'h0);
        check("edge_err", 48'(err2), 48'h0);
        check("edge_smp", 48'(smp2[11:0]), 48'h123);

        // Timeout
        do_reset();
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check("to_den", 48'(den2), 48'd1);
        cyc = 0;
        while (tmo2 !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
        check("to_latency", 48'(cyc), 48'd256);
        check("to_err", 48'(err2), 48'h1);
        tick();
        check("to_pulse_end", 48'(tmo2), 48'h0);
        check("to_err_sticky", 48'(err2), 48'h1);
        drdy = 1'b1;
        tick();
        drdy = 1'b0;
        tick();
        check("to_stray_vld", 48'(vld2), 48'h0);
        rd(16'h8000);
        check("to_next_addr", 48'(a2_seen), 48'h17);
        check("to_err_hold", 48'(err2), 48'h1);

        // Three-channel round robin
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rd(16'h8000);
            check($sformatf("rr_addr%0d", i), 48'(a3_seen), 48'(seq_a[i]));
            check($sformatf("rr_vld%0d", i),  48'(vld3),    48'(seq_v[i]));
        end

        // Reset during WAIT, late drdy ignored
        do_reset();
        rd(16'hF000);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        rst = 1'b1;
        #2;
        check("mid_rst_smp", 48'(smp2), 48'h0);
        tick();
        rst = 1'b0;
        tick();
        din  = 16'hF000;
        drdy = 1'b1;
        tick();
        drdy = 1'b0;
        check("mid_vld",  48'(vld2),  48'h0);
        check("mid_den",  48'(den2),  48'h0);
        check("mid_addr", 48'(addr2), 48'h16);
        check("mid_dir",  48'(dir2),  48'h5);
        check("mid_smp",  48'(smp2),  48'h0);
        check("mid_err",  48'(err2),  48'h0);
        tick();
        check("mid_vld2", 48'(vld2), 48'h0);
        rd(16'h8000);
        check("mid_next_addr", 48'(a2_seen), 48'h16);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
